cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter: A_WIDTH, default 32, address width of all ports.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the grant statistics counters.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low (ports clk, clrn); polarity and synchronicity are fixed.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 clrn  input  1  synchronous active-low reset.
REQ-006 ic_a  input  A_WIDTH  instruction-cache miss address.
REQ-007 ic_strobe  input  1  instruction-cache read request; held until ic_ready.
REQ-008 ic_dout  output  32  read data to instruction cache.
REQ-009 ic_ready  output  1  instruction-cache transfer complete.
REQ-010 dc_a  input  A_WIDTH  data-cache address.
REQ-011 dc_din  input  32  data-cache write data.
REQ-012 dc_strobe  input  1  data-cache request; held until dc_ready.
REQ-013 dc_rw  input  1  data-cache direction (0 read, 1 write).
REQ-014 dc_dout  output  32  read data to data cache.
REQ-015 dc_ready  output  1  data-cache transfer complete.
REQ-016 m_a  output  A_WIDTH  memory address.
REQ-017 m_din  output  32  memory write data.
REQ-018 m_strobe  output  1  memory request.
REQ-019 m_rw  output  1  memory direction (0 read, 1 write).
REQ-020 m_dout  input  32  memory read data.
REQ-021 m_ready  input  1  memory transfer complete.
REQ-022 ic_grants, dc_grants  output  CNT_WIDTH each  saturating counts of grants issued.

Function
REQ-023 FSM states: IDLE, SERVE_IC, SERVE_DC; exactly one owner of the memory port outside IDLE.
REQ-024 IDLE: m_strobe=0, m_rw=0, m_a=0, m_din=0, ic_ready=0, dc_ready=0.
REQ-025 IDLE with one strobe high: next state is the SERVE state of that requester.
REQ-026 IDLE with both strobes high: grant goes to the requester not served last (last_owner flag); after reset last_owner=IC, so DC wins the first tie.
REQ-027 Grant latency: strobe seen in IDLE at edge N, m_strobe high from cycle N+1.
REQ-028 SERVE_x: m_a/m_din/m_rw/m_strobe pass through combinationally from owner; m_rw forced 0 in SERVE_IC.
REQ-029 SERVE_x: x_ready = m_ready (same cycle); non-owner ready stays 0.
REQ-030 Both ic_dout and dc_dout = m_dout at all times; validity qualified only by the respective ready.
REQ-031 SERVE_x with m_ready=1: next state IDLE, last_owner<=x; one idle bubble cycle is mandatory between transfers.
REQ-032 SERVE_x with owner strobe dropped before m_ready (abort): m_strobe falls the same cycle; next state IDLE; last_owner unchanged.
REQ-033 Non-owner strobe during SERVE_x is held pending; no effect until IDLE.
REQ-034 Grant counters increment on each IDLE->SERVE transition, saturate at all-ones, never wrap.

Reset
REQ-035 clrn=0 at an edge: state IDLE, last_owner=IC, both counters 0; outputs follow REQ-024 from the next cycle.
REQ-036 Reset mid-transfer abandons the transfer; no ready is issued for it.

Structure
REQ-037 Shared package: state encoding (2-bit), owner encoding (IC=0, DC=1).
REQ-038 One sub-module, rr_arb2: combinational two-requester round-robin pick given last_owner.

Verification
REQ-039 Single DC write: dc_strobe=1, dc_rw=1, dc_a=0x100, dc_din=0xDEADBEEF, m_ready at 3rd SERVE cycle -> m_a=0x100, m_din=0xDEADBEEF, m_rw=1, dc_ready pulses once, dc_grants=1.
REQ-040 Simultaneous strobes after reset -> DC served first, then IC after one IDLE cycle; ic_ready never high during SERVE_DC.
REQ-041 Both strobes held continuously for 6 transfers -> grants alternate DC,IC,DC,IC,DC,IC; counters 3/3.
REQ-042 IC abort: ic_strobe drops in 2nd SERVE_IC cycle, m_ready never -> m_strobe falls same cycle, IDLE next, ic_grants=1, no ic_ready.
REQ-043 Reset asserted during SERVE_DC -> IDLE next cycle, m_strobe=0, counters 0, no dc_ready.
REQ-044 CNT_WIDTH=2, 5 IC transfers -> ic_grants saturates at 3.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings for the cache-to-memory arbiter: FSM states and memory-port owner.
`timescale 1ns/1ps
package cache_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SERVE_IC = 2'd1,
      ST_SERVE_DC = 2'd2
   } state_e;

   typedef enum logic {
      OWNER_IC = 1'b0,
      OWNER_DC = 1'b1
   } owner_e;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-requester round-robin pick: on a tie the requester not served last wins.
`timescale 1ns/1ps
module rr_arb2
   import cache_mem_arbiter_pkg::*;
(
   input  logic req_ic,
   input  logic req_dc,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_dc
);

   always_comb begin
      grant_valid = req_ic | req_dc;
      grant_dc    = req_dc;
      if (req_ic && req_dc) begin
         grant_dc = (last_owner == OWNER_IC);
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one memory port between an instruction cache (read only) and a data cache.
`timescale 1ns/1ps
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int A_WIDTH   = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 clrn,
   input  logic [A_WIDTH-1:0]   ic_a,
   input  logic                 ic_strobe,
   output logic [31:0]          ic_dout,
   output logic                 ic_ready,
   input  logic [A_WIDTH-1:0]   dc_a,
   input  logic [31:0]          dc_din,
   input  logic                 dc_strobe,
   input  logic                 dc_rw,
   output logic [31:0]          dc_dout,
   output logic                 dc_ready,
   output logic [A_WIDTH-1:0]   m_a,
   output logic [31:0]          m_din,
   output logic                 m_strobe,
   output logic                 m_rw,
   input  logic [31:0]          m_dout,
   input  logic                 m_ready,
   output logic [CNT_WIDTH-1:0] ic_grants,
   output logic [CNT_WIDTH-1:0] dc_grants
);

   state_e                state_q, state_d;
   owner_e                last_owner_q, last_owner_d;
   logic [CNT_WIDTH-1:0]  ic_grants_q, ic_grants_d;
   logic [CNT_WIDTH-1:0]  dc_grants_q, dc_grants_d;
   logic                  grant_valid;
   logic                  grant_dc;

   rr_arb2 u_rr_arb2 (
      .req_ic      (ic_strobe),
      .req_dc      (dc_strobe),
      .last_owner  (last_owner_q),
      .grant_valid (grant_valid),
      .grant_dc    (grant_dc)
   );

   assign ic_dout   = m_dout;
   assign dc_dout   = m_dout;
   assign ic_grants = ic_grants_q;
   assign dc_grants = dc_grants_q;

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q      <= ST_IDLE;
         last_owner_q <= OWNER_IC;
         ic_grants_q  <= '0;
         dc_grants_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         ic_grants_q  <= ic_grants_d;
         dc_grants_q  <= dc_grants_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      ic_grants_d  = ic_grants_q;
      dc_grants_d  = dc_grants_q;
      m_a          = '0;
      m_din        = '0;
      m_strobe     = 1'b0;
      m_rw         = 1'b0;
      ic_ready     = 1'b0;
      dc_ready     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               if (grant_dc) begin
                  state_d = ST_SERVE_DC;
                  if (dc_grants_q != '1) dc_grants_d = dc_grants_q + CNT_WIDTH'(1);
               end else begin
                  state_d = ST_SERVE_IC;
                  if (ic_grants_q != '1) ic_grants_d = ic_grants_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_SERVE_IC: begin
            m_a      = ic_a;
            m_strobe = ic_strobe;
            // A dropped strobe is an abort; the memory's late ready must not leak through.
            ic_ready = m_ready & ic_strobe & clrn;
            if (!ic_strobe) begin
               state_d = ST_IDLE;
            end else if (m_ready) begin
               state_d      = ST_IDLE;
               last_owner_d = OWNER_IC;
            end
         end
         ST_SERVE_DC: begin
            m_a      = dc_a;
            m_din    = dc_din;
            m_rw     = dc_rw;
            m_strobe = dc_strobe;
            dc_ready = m_ready & dc_strobe & clrn;
            if (!dc_strobe) begin
               state_d = ST_IDLE;
            end else if (m_ready) begin
               state_d      = ST_IDLE;
               last_owner_d = OWNER_DC;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed-vector bench for cache_mem_arbiter, plus a 2-bit-counter instance for saturation.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

   logic        clk = 1'b0;
   logic        clrn;
   logic [31:0] ic_a, dc_a, dc_din, m_dout, m_a, m_din, ic_dout, dc_dout;
   logic        ic_strobe, dc_strobe, dc_rw, m_ready;
   logic        ic_ready, dc_ready, m_strobe, m_rw;
   logic [15:0] ic_grants, dc_grants;

   logic [31:0] s_ic_a, s_dc_a, s_dc_din, s_m_dout, s_m_a, s_m_din, s_ic_dout, s_dc_dout;
   logic        s_ic_strobe, s_dc_strobe, s_dc_rw, s_m_ready;
   logic        s_ic_ready, s_dc_ready, s_m_strobe, s_m_rw;
   logic [1:0]  s_ic_grants, s_dc_grants;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cache_mem_arbiter #(.A_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk(clk), .clrn(clrn),
      .ic_a(ic_a), .ic_strobe(ic_strobe), .ic_dout(ic_dout), .ic_ready(ic_ready),
      .dc_a(dc_a), .dc_din(dc_din), .dc_strobe(dc_strobe), .dc_rw(dc_rw),
      .dc_dout(dc_dout), .dc_ready(dc_ready),
      .m_a(m_a), .m_din(m_din), .m_strobe(m_strobe), .m_rw(m_rw),
      .m_dout(m_dout), .m_ready(m_ready),
      .ic_grants(ic_grants), .dc_grants(dc_grants)
   );

   cache_mem_arbiter #(.A_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .clrn(clrn),
      .ic_a(s_ic_a), .ic_strobe(s_ic_strobe), .ic_dout(s_ic_dout), .ic_ready(s_ic_ready),
      .dc_a(s_dc_a), .dc_din(s_dc_din), .dc_strobe(s_dc_strobe), .dc_rw(s_dc_rw),
      .dc_dout(s_dc_dout), .dc_ready(s_dc_ready),
      .m_a(s_m_a), .m_din(s_m_din), .m_strobe(s_m_strobe), .m_rw(s_m_rw),
      .m_dout(s_m_dout), .m_ready(s_m_ready),
      .ic_grants(s_ic_grants), .dc_grants(s_dc_grants)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ic_strobe = 1'b0; dc_strobe = 1'b0; m_ready = 1'b0; dc_rw = 1'b0;
      clrn = 1'b0;
      cycle();
      clrn = 1'b1;
   endtask

   task automatic test_reset();
      ic_a = 32'h0000_0AAA; dc_a = 32'h0000_0BBB; dc_din = 32'h1234_5678; m_dout = 32'hCAFE_F00D;
      s_ic_a = 32'h40; s_dc_a = 32'h0; s_dc_din = 32'h0; s_m_dout = 32'h0;
      s_ic_strobe = 1'b0; s_dc_strobe = 1'b0; s_dc_rw = 1'b0; s_m_ready = 1'b0;
      do_reset();
      vectors++; if (m_strobe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_strobe actual=%0h required=0", m_strobe); end
      vectors++; if (m_a !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_m_a actual=%0h required=0", m_a); end
      vectors++; if (m_din !== 32'h0 || m_rw !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_din_rw actual=%0h/%0h required=0/0", m_din, m_rw); end
      vectors++; if (ic_ready !== 1'b0 || dc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready actual=%0h/%0h required=0/0", ic_ready, dc_ready); end
      vectors++; if (ic_grants !== 16'd0 || dc_grants !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_grants actual=%0d/%0d required=0/0", ic_grants, dc_grants); end
      vectors++; if (ic_dout !== 32'hCAFE_F00D || dc_dout !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL reset_dout actual=%0h/%0h required=cafef00d", ic_dout, dc_dout); end
   endtask

   task automatic test_dc_write();
      int ready_pulses;
      do_reset();
      dc_a = 32'h100; dc_din = 32'hDEAD_BEEF; dc_rw = 1'b1; dc_strobe = 1'b1;
      #1;
      vectors++; if (m_strobe !== 1'b0) begin miscompares++; $display("[TB] FAIL dcw_latency_m_strobe actual=%0h required=0", m_strobe); end
      ready_pulses = 0;
      for (int c = 1; c <= 3; c++) begin
         cycle();
         if (c == 3) begin m_ready = 1'b1; #1; end
         if (dc_ready === 1'b1) ready_pulses++;
         vectors++; if (m_strobe !== 1'b1 || m_a !== 32'h100 || m_din !== 32'hDEAD_BEEF || m_rw !== 1'b1) begin
            miscompares++; $display("[TB] FAIL dcw_port_c%0d actual=%0h/%0h/%0h/%0h required=1/100/deadbeef/1", c, m_strobe, m_a, m_din, m_rw); end
      end
      cycle();
      m_ready = 1'b0; dc_strobe = 1'b0; dc_rw = 1'b0;
      #1;
      if (dc_ready === 1'b1) ready_pulses++;
      vectors++; if (ready_pulses !== 1) begin miscompares++; $display("[TB] FAIL dcw_ready_pulses actual=%0d required=1", ready_pulses); end
      vectors++; if (m_strobe !== 1'b0) begin miscompares++; $display("[TB] FAIL dcw_idle_m_strobe actual=%0h required=0", m_strobe); end
      vectors++; if (dc_grants !== 16'd1 || ic_grants !== 16'd0) begin miscompares++; $display("[TB] FAIL dcw_grants actual=%0d/%0d required=1/0", dc_grants, ic_grants); end
   endtask

   task automatic test_tie_after_reset();
      do_reset();
      ic_a = 32'h200; dc_a = 32'h300; dc_rw = 1'b0;
      ic_strobe = 1'b1; dc_strobe = 1'b1;
      cycle();
      vectors++; if (m_a !== 32'h300 || m_strobe !== 1'b1) begin miscompares++; $display("[TB] FAIL tie_first_dc actual=%0h/%0h required=300/1", m_a, m_strobe); end
      vectors++; if (ic_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL tie_ic_ready_in_dc actual=%0h required=0", ic_ready); end
      m_ready = 1'b1; #1;
      vectors++; if (dc_ready !== 1'b1 || ic_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL tie_dc_done actual=%0h/%0h required=1/0", dc_ready, ic_ready); end
      cycle();
      m_ready = 1'b0; dc_strobe = 1'b0; #1;
      vectors++; if (m_strobe !== 1'b0 || ic_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL tie_bubble actual=%0h/%0h required=0/0", m_strobe, ic_ready); end
      cycle();
      vectors++; if (m_a !== 32'h200 || m_strobe !== 1'b1 || m_rw !== 1'b0) begin miscompares++; $display("[TB] FAIL tie_then_ic actual=%0h/%0h/%0h required=200/1/0", m_a, m_strobe, m_rw); end
      m_ready = 1'b1; #1;
      vectors++; if (ic_ready !== 1'b1 || dc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL tie_ic_done actual=%0h/%0h required=1/0", ic_ready, dc_ready); end
      cycle();
      m_ready = 1'b0; ic_strobe = 1'b0; #1;
   endtask

   task automatic test_back_to_back();
      logic exp_dc;
      do_reset();
      ic_a = 32'h0000_1000; dc_a = 32'h0000_2000; dc_rw = 1'b0;
      ic_strobe = 1'b1; dc_strobe = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_dc = (k % 2 == 0);
         cycle();
         vectors++; if (m_a !== (exp_dc ? 32'h0000_2000 : 32'h0000_1000)) begin miscompares++; $display("[TB] FAIL b2b_owner_%0d actual=%0h required=%0h", k, m_a, exp_dc ? 32'h2000 : 32'h1000); end
         m_ready = 1'b1; #1;
         vectors++; if (dc_ready !== exp_dc || ic_ready !== !exp_dc) begin miscompares++; $display("[TB] FAIL b2b_ready_%0d actual=%0h/%0h required=%0h/%0h", k, dc_ready, ic_ready, exp_dc, !exp_dc); end
         cycle();
         m_ready = 1'b0; #1;
      end
      vectors++; if (ic_grants !== 16'd3 || dc_grants !== 16'd3) begin miscompares++; $display("[TB] FAIL b2b_grants actual=%0d/%0d required=3/3", ic_grants, dc_grants); end
      ic_strobe = 1'b0; dc_strobe = 1'b0;
   endtask

   task automatic test_ic_abort();
      do_reset();
      ic_a = 32'h0000_0440; ic_strobe = 1'b1;
      cycle();
      vectors++; if (m_strobe !== 1'b1 || m_a !== 32'h440) begin miscompares++; $display("[TB] FAIL abort_serve actual=%0h/%0h required=1/440", m_strobe, m_a); end
      cycle();
      ic_strobe = 1'b0; #1;
      vectors++; if (m_strobe !== 1'b0 || ic_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_drop actual=%0h/%0h required=0/0", m_strobe, ic_ready); end
      cycle();
      vectors++; if (m_strobe !== 1'b0 || ic_ready !== 1'b0 || ic_grants !== 16'd1) begin miscompares++; $display("[TB] FAIL abort_idle actual=%0h/%0h/%0d required=0/0/1", m_strobe, ic_ready, ic_grants); end
      dc_a = 32'h0000_0880; dc_rw = 1'b0; ic_strobe = 1'b1; dc_strobe = 1'b1;
      cycle();
      vectors++; if (m_a !== 32'h880) begin miscompares++; $display("[TB] FAIL abort_last_owner actual=%0h required=880", m_a); end
      ic_strobe = 1'b0; dc_strobe = 1'b0;
   endtask

   task automatic test_reset_mid_transfer();
      do_reset();
      dc_a = 32'h0000_0C00; dc_din = 32'h5555_AAAA; dc_rw = 1'b1; dc_strobe = 1'b1;
      cycle();
      cycle();
      clrn = 1'b0;
      cycle();
      vectors++; if (m_strobe !== 1'b0 || dc_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_idle actual=%0h/%0h required=0/0", m_strobe, dc_ready); end
      vectors++; if (dc_grants !== 16'd0 || ic_grants !== 16'd0) begin miscompares++; $display("[TB] FAIL midrst_grants actual=%0d/%0d required=0/0", dc_grants, ic_grants); end
      dc_strobe = 1'b0; dc_rw = 1'b0;
      clrn = 1'b1;
   endtask

   task automatic test_saturation();
      int exp_cnt;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         s_ic_strobe = 1'b1;
         cycle();
         s_m_ready = 1'b1; #1;
         vectors++; if (s_ic_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_ready_%0d actual=%0h required=1", k, s_ic_ready); end
         cycle();
         s_m_ready = 1'b0; s_ic_strobe = 1'b0; #1;
         exp_cnt = (k > 3) ? 3 : k;
         vectors++; if (s_ic_grants !== 2'(exp_cnt)) begin miscompares++; $display("[TB] FAIL sat_count_%0d actual=%0d required=%0d", k, s_ic_grants, exp_cnt); end
      end
   endtask

   initial begin
      clrn = 1'b0; ic_strobe = 1'b0; dc_strobe = 1'b0; dc_rw = 1'b0; m_ready = 1'b0;
      test_reset();
      test_dc_write();
      test_tie_after_reset();
      test_back_to_back();
      test_ic_abort();
      test_reset_mid_transfer();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
